// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot instruction-cycle sequencer with per-phase dwell, stall, flush and retire count.
module phase_sequencer #(
  parameter int PHASES  = 4,
  parameter int DWELL_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic [PHASES*DWELL_W-1:0]   dwell_i,
  output logic [PHASES-1:0]           phase_o,
  output logic [$clog2(PHASES)-1:0]   phase_index_o,
  output logic                        phase_done_o,
  output logic                        busy_o,
  output logic                        retire_o,
  output logic [CNT_W-1:0]            instr_count_o
);
  localparam int IW = $clog2(PHASES);
  localparam logic [IW-1:0] LAST = IW'(PHASES - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d, nidx;
  logic [DWELL_W-1:0]  remain_q, remain_d;
  logic [PHASES-1:0]   phase_q, phase_d;
  logic                retire_q, retire_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DWELL_W-1:0]  dw [PHASES];
  for (genvar g = 0; g < PHASES; g++) begin : g_dw
    assign dw[g] = dwell_i[g*DWELL_W +: DWELL_W];
  end
  assign nidx = idx_q + 1'b1;
  // Flush outranks stall; enable only matters in IDLE and at the end of the last phase.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    retire_d = 1'b0;
    cnt_d    = cnt_q;
    if (state_q == IDLE) begin
      if (enable_i || flush_i) begin
        state_d  = RUN;
        idx_d    = '0;
        remain_d = dw[0];
      end
    end else if (flush_i) begin
      idx_d    = '0;
      remain_d = dw[0];
    end else if (!stall_i) begin
      if (remain_q != '0) begin
        remain_d = remain_q - 1'b1;
      end else if (idx_q != LAST) begin
        idx_d    = nidx;
        remain_d = dw[nidx];
      end else begin
        retire_d = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        idx_d    = '0;
        state_d  = enable_i ? RUN : IDLE;
        remain_d = enable_i ? dw[0] : '0;
      end
    end
    phase_d = (state_d == RUN) ? ({{(PHASES-1){1'b0}}, 1'b1} << idx_d) : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      phase_q  <= '0;
      retire_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      phase_q  <= phase_d;
      retire_q <= retire_d;
      cnt_q    <= cnt_d;
    end
  end
  assign busy_o        = state_q == RUN;
  assign phase_o       = phase_q;
  assign phase_index_o = idx_q;
  assign retire_o      = retire_q;
  assign instr_count_o = cnt_q;
  assign phase_done_o  = (remain_q == '0) && busy_o && !stall_i;
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: vector table plus scoreboard queue, then async reset and counter-wrap sequences.
module tb_phase_sequencer;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, st = 1'b0, fl = 1'b0;
  logic [15:0] dw = '0;
  logic [3:0] ph, cnt;
  logic [1:0] pidx;
  logic done, busy, ret;
  always #5 clk = ~clk;
  phase_sequencer #(.PHASES(4), .DWELL_W(4), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .stall_i(st), .flush_i(fl), .dwell_i(dw),
    .phase_o(ph), .phase_index_o(pidx), .phase_done_o(done), .busy_o(busy),
    .retire_o(ret), .instr_count_o(cnt)
  );
  // in = {enable, stall, flush}; flg = {busy, phase_done, retire}; outputs expected in the cycle the inputs are applied
  typedef struct packed {
    logic [2:0]  in;
    logic [15:0] dw;
    logic [3:0]  ph;
    logic [2:0]  flg;
    logic [3:0]  cnt;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int checks = 0, errors = 0;
  task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", n, i, a, e);
    end
  endtask
  function automatic void add(input logic [2:0] i, input logic [15:0] d, input logic [3:0] p,
                              input logic [2:0] f, input logic [3:0] c);
    vecs.push_back('{i, d, p, f, c});
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    vec_t e;
    add(3'b100, 16'h0, 4'b0000, 3'b000, 4'd0);
    add(3'b100, 16'h0, 4'b0001, 3'b110, 4'd0);
    add(3'b100, 16'h0, 4'b0010, 3'b110, 4'd0);
    add(3'b100, 16'h0, 4'b0100, 3'b110, 4'd0);
    add(3'b100, 16'h0, 4'b1000, 3'b110, 4'd0);
    add(3'b100, 16'h0, 4'b0001, 3'b111, 4'd1);
    add(3'b000, 16'h0, 4'b0010, 3'b110, 4'd1);
    add(3'b000, 16'h0, 4'b0100, 3'b110, 4'd1);
    add(3'b000, 16'h0, 4'b1000, 3'b110, 4'd1);
    add(3'b000, 16'h0, 4'b0000, 3'b001, 4'd2);
    add(3'b000, 16'h0, 4'b0000, 3'b000, 4'd2);
    add(3'b100, 16'h0, 4'b0000, 3'b000, 4'd2);
    add(3'b100, 16'h0, 4'b0001, 3'b110, 4'd2);
    add(3'b100, 16'h0, 4'b0010, 3'b110, 4'd2);
    add(3'b110, 16'h0, 4'b0100, 3'b100, 4'd2);
    add(3'b110, 16'h0, 4'b0100, 3'b100, 4'd2);
    add(3'b110, 16'h0, 4'b0100, 3'b100, 4'd2);
    add(3'b100, 16'h0, 4'b0100, 3'b110, 4'd2);
    add(3'b100, 16'h0, 4'b1000, 3'b110, 4'd2);
    add(3'b100, 16'h0, 4'b0001, 3'b111, 4'd3);
    add(3'b100, 16'h0, 4'b0010, 3'b110, 4'd3);
    add(3'b101, 16'h0, 4'b0100, 3'b110, 4'd3);
    add(3'b100, 16'h0, 4'b0001, 3'b110, 4'd3);
    add(3'b100, 16'h0, 4'b0010, 3'b110, 4'd3);
    add(3'b100, 16'h0, 4'b0100, 3'b110, 4'd3);
    add(3'b111, 16'h0, 4'b1000, 3'b100, 4'd3);
    add(3'b100, 16'h0, 4'b0001, 3'b110, 4'd3);
    add(3'b000, 16'h0, 4'b0010, 3'b110, 4'd3);
    add(3'b000, 16'h0, 4'b0100, 3'b110, 4'd3);
    add(3'b000, 16'h0, 4'b1000, 3'b110, 4'd3);
    add(3'b000, 16'h0, 4'b0000, 3'b001, 4'd4);
    add(3'b100, 16'h0210, 4'b0000, 3'b000, 4'd4);
    add(3'b100, 16'h0210, 4'b0001, 3'b110, 4'd4);
    add(3'b100, 16'h0210, 4'b0010, 3'b100, 4'd4);
    add(3'b100, 16'h0210, 4'b0010, 3'b110, 4'd4);
    add(3'b100, 16'h0F10, 4'b0100, 3'b100, 4'd4);
    add(3'b100, 16'h0210, 4'b0100, 3'b100, 4'd4);
    add(3'b100, 16'h0210, 4'b0100, 3'b110, 4'd4);
    add(3'b000, 16'h0210, 4'b1000, 3'b110, 4'd4);
    add(3'b000, 16'h0, 4'b0000, 3'b001, 4'd5);
    add(3'b001, 16'h0, 4'b0000, 3'b000, 4'd5);
    add(3'b100, 16'h0, 4'b0001, 3'b110, 4'd5);
    #1 rst = 1'b1;
    #2;
    chk("rst_phase", 0, 32'(ph), 32'h0);
    chk("rst_index", 0, 32'(pidx), 32'h0);
    chk("rst_busy", 0, 32'(busy), 32'h0);
    chk("rst_done", 0, 32'(done), 32'h0);
    chk("rst_retire", 0, 32'(ret), 32'h0);
    chk("rst_count", 0, 32'(cnt), 32'h0);
    #9 rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      {en, st, fl} = vecs[i].in;
      dw = vecs[i].dw;
      sb.push_back(vecs[i]);
      #1;
      e = sb.pop_front();
      chk("phase", i, 32'(ph), 32'(e.ph));
      chk("busy", i, 32'(busy), 32'(e.flg[2]));
      chk("phase_done", i, 32'(done), 32'(e.flg[1]));
      chk("retire", i, 32'(ret), 32'(e.flg[0]));
      chk("count", i, 32'(cnt), 32'(e.cnt));
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_phase", 100, 32'(ph), 32'h4);
    chk("mid_index", 100, 32'(pidx), 32'h2);
    chk("mid_count", 100, 32'(cnt), 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("async_phase", 101, 32'(ph), 32'h0);
    chk("async_index", 101, 32'(pidx), 32'h0);
    chk("async_busy", 101, 32'(busy), 32'h0);
    chk("async_count", 101, 32'(cnt), 32'h0);
    en = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_hold_busy", 102, 32'(busy), 32'h0);
    chk("idle_hold_phase", 102, 32'(ph), 32'h0);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_phase", 103, 32'(ph), 32'h1);
    chk("restart_count", 103, 32'(cnt), 32'h0);
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (k % 4 == 0) begin
        chk("wrap_count", 200 + k, 32'(cnt), 32'((k / 4) % 16));
        chk("wrap_retire", 200 + k, 32'(ret), 32'h1);
      end
    end
    chk("wrap_phase", 264, 32'(ph), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised instruction-cycle sequencer driving the CPU control path. It generalises the fixed four-phase fetch/decode/execute/writeback ring to PHASES one-hot phases. Each phase has a programmable dwell time, and the block adds stall, flush, an idle state and a retired-instruction counter. Downstream control logic qualifies register and memory strobes with `phase` and `phase_done`.

## Interface
- PHASES, default 4: number of phases; phase 0 is fetch. Legal range 2–16.
- DWELL_W, default 4: width of each per-phase dwell field.
- CNT_W, default 16: width of the retired-instruction counter.
- clock  in  1: single system clock; all state updates on its rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- enable  in  1: run request; sampled only in IDLE and at the end of the last phase.
- stall  in  1: freezes phase, dwell counter and instruction counter.
- flush  in  1: forces re-entry at phase 0 on the next edge; has priority over stall.
- dwell  in  PHASES*DWELL_W: field i holds the extra cycles for phase i (phase lasts dwell_i+1 cycles); sampled on phase entry.
- phase  out  PHASES: one-hot current phase; all zero in IDLE.
- phase_index  out  $clog2(PHASES): binary index of the current phase; 0 in IDLE.
- phase_done  out  1: high in the final cycle of the current phase when stall=0.
- busy  out  1: high when not IDLE.
- retire  out  1: one-cycle pulse on the edge that leaves the last phase.
- instr_count  out  CNT_W: number of retired instructions; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, and RUN(i) for i in 0..PHASES-1. A down-counter `remain` of width DWELL_W tracks the cycles left in the current phase.
- Reset, asynchronous: state=IDLE, phase=0, phase_index=0, remain=0, instr_count=0, retire=0. phase_done and busy are 0 as a consequence.
- Edge priority, highest first: reset, then flush, then stall, then normal advance.
- IDLE:
  - enable=1 → RUN(0), remain=dwell_0.
  - enable=0 → stay in IDLE.
  - flush in IDLE behaves as enable=1.
- RUN(i), no stall or flush:
  - remain>0 → remain decrements, phase unchanged.
  - remain=0, i<PHASES-1 → RUN(i+1), remain=dwell_{i+1}.
  - remain=0, i=PHASES-1 → retire=1, instr_count+1, then RUN(0) with remain=dwell_0 if enable=1, else IDLE.
- stall=1, no flush: all state holds, retire=0, phase_done=0.
- flush=1 (any RUN state, stalled or not): RUN(0), remain=dwell_0, no retire, instr_count unchanged.
- phase_done is combinational: (remain==0) & busy & ~stall.
- Changes to `dwell` mid-phase have no effect until the next phase entry.

## Timing
- Every output except phase_done is registered.
- Latency: first edge with enable=1 in IDLE → phase[0]=1 after that edge.
- With all dwell=0, one instruction takes PHASES cycles; phase advances on every edge, matching the legacy 4-phase ring.
- Total instruction length is the sum over i of (dwell_i+1) cycles, plus stalled cycles.
- retire is high for exactly the one cycle following the edge that leaves the last phase.
- instr_count increments once per retire and wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-phase → outputs clear within the same cycle, with no clock edge required. Deassertion → stays in IDLE until the first edge with enable=1.
- stall and flush asserted in the same cycle → flush wins.
- enable deasserted mid-instruction → the current instruction completes, then the block enters IDLE.

## Test plan
- Reset then run, PHASES=4, dwell=0, enable=1:
  - Reset → phase=0000, busy=0.
  - Following edges give phase = 0001, 0010, 0100, 1000, 0001.
  - retire pulses once; instr_count=1.
- Dwell, dwell={3:0, 2:2, 1:1, 0:0}:
  - Phase occupancy is 1, 2, 3, 1 cycles.
  - phase_done is high only in the last cycle of each phase.
  - Instruction takes 7 cycles.
- Stall during phase 2 for 3 cycles:
  - phase holds 0100, phase_done=0.
  - Instruction length becomes PHASES+3.
  - instr_count unchanged until retire.
- Flush:
  - Flush in phase 2 → next edge phase=0001, no retire.
  - flush+stall together in phase 3 → phase=0001.
- Enable drop: enable low during phase 1 → instruction completes, retire=1, then phase=0000, busy=0. Re-enable → phase=0001 after one edge.
- Reset and counter wrap, CNT_W=4:
  - Asynchronous reset mid-phase 2 → phase=0000 and instr_count=0 before the next edge.
  - Counter wrap: run 16 instructions → instr_count returns to 0.
